// File: rtl/lsu_mem_pipe_pkg.sv
// Shared types for the LSU memory stage.
// micro_op_t is the issued uop bundle seen by lsu_mem_pipe.
package lsu_mem_pipe_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef struct packed {
    logic            valid;
    logic            is_store;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
  } micro_op_t;

endpackage

// File: rtl/lsu_mem_pipe_if.sv
// Data-memory req/gnt/resp bus for the LSU memory stage.
// master = LSU side, slave = memory side.
interface lsu_mem_pipe_if #(
  parameter int XLEN   = 32,
  parameter int STRB_W = 4
);

  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_gnt;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_wstrb,
    input  mem_gnt, mem_resp_valid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_wstrb,
    output mem_gnt, mem_resp_valid, mem_rdata
  );

endinterface

// File: rtl/lsu_mem_pipe.sv
// LSU memory stage: one load/store in flight, req/gnt/resp to dmem.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning.
module lsu_mem_pipe
  import lsu_mem_pipe_pkg::*;
#(
  parameter int XLEN   = lsu_mem_pipe_pkg::XLEN,
  parameter int STRB_W = XLEN / 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear_en,
  input  micro_op_t           uop_in,
  input  logic [XLEN-1:0]     rs1_data,
  input  logic [XLEN-1:0]     rs2_data,
  output logic                ex_busy,
  lsu_mem_pipe_if.master      mem,
  output logic                wb_valid,
  output micro_op_t           wb_uop,
  output logic [XLEN-1:0]     wb_data,
  output logic                wb_misaligned
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t            r_state;
  state_t            w_next;
  micro_op_t         r_uop;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_rs2;
  logic [XLEN-1:0]   r_data;
  logic              r_mis;

  logic [XLEN-1:0]   w_addr;
  logic [XLEN-1:0]   w_lat_addr;
  logic              w_trap;
  logic              w_req;
  logic              w_done;
  logic [4:0]        w_sh;
  logic [STRB_W-1:0] w_mask;
  logic [XLEN-1:0]   w_rsh;
  logic [XLEN-1:0]   w_ld;

  assign w_addr = rs1_data + uop_in.imm;

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_mis;
  always_comb begin
    w_mis = 1'b0;
    unique case (1'b1)
      uop_in.mem_size == SZ_H: w_mis = w_addr[0];
      uop_in.mem_size == SZ_W: w_mis = |w_addr[1:0];
      default:                 w_mis = 1'b0;
    endcase
  end
  assign w_trap     = w_mis;
  assign w_lat_addr = w_addr;
`else
  logic [XLEN-1:0] w_align;
  always_comb begin
    w_align = w_addr;
    unique case (1'b1)
      uop_in.mem_size == SZ_H: w_align = {w_addr[XLEN-1:1], 1'b0};
      uop_in.mem_size == SZ_W: w_align = {w_addr[XLEN-1:2], 2'b00};
      default:                 w_align = w_addr;
    endcase
  end
  assign w_trap     = 1'b0;
  assign w_lat_addr = w_align;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (!clear_en && uop_in.valid)
          w_next = w_trap ? S_DONE : S_REQ;
      end
      S_REQ: begin
        // a granted load is already in memory's hands: wait out its resp
        if (clear_en)
          w_next = (mem.mem_gnt && !r_uop.is_store)
                   ? S_DRAIN : S_IDLE;
        else if (mem.mem_gnt)
          w_next = r_uop.is_store ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (clear_en)
          w_next = S_DRAIN;
        else if (mem.mem_resp_valid)
          w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      S_DRAIN: begin
        if (mem.mem_resp_valid)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_uop   <= '0;
      r_addr  <= '0;
      r_rs2   <= '0;
      r_data  <= '0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_next != S_IDLE) begin
        r_uop  <= uop_in;
        r_addr <= w_lat_addr;
        r_rs2  <= rs2_data;
        r_data <= '0;
        r_mis  <= w_trap;
      end
      if (r_state == S_WAIT && w_next == S_DONE)
        r_data <= w_ld;
    end
  end

  assign w_sh = {r_addr[1:0], 3'b000};

  always_comb begin
    w_mask = '1;
    unique case (1'b1)
      r_uop.mem_size == SZ_B: w_mask = STRB_W'(1);
      r_uop.mem_size == SZ_H: w_mask = STRB_W'(3);
      default:                w_mask = '1;
    endcase
  end

  assign w_rsh = mem.mem_rdata >> w_sh;

  always_comb begin
    w_ld = '0;
    unique case (1'b1)
      r_uop.mem_size == SZ_B:
        w_ld = {{(XLEN-8){~r_uop.mem_unsigned & w_rsh[7]}},
                w_rsh[7:0]};
      r_uop.mem_size == SZ_H:
        w_ld = {{(XLEN-16){~r_uop.mem_unsigned & w_rsh[15]}},
                w_rsh[15:0]};
      default: w_ld = w_rsh;
    endcase
  end

  assign w_req  = (r_state == S_REQ);
  assign w_done = (r_state == S_DONE);

  assign ex_busy       = (r_state != S_IDLE);
  assign mem.mem_req   = w_req;
  assign mem.mem_we    = w_req & r_uop.is_store;
  assign mem.mem_addr  = w_req ? r_addr : '0;
  assign mem.mem_wstrb = w_req ? (w_mask << r_addr[1:0]) : '0;
  assign mem.mem_wdata = (w_req && r_uop.is_store)
                         ? (r_rs2 << w_sh) : '0;

  assign wb_valid      = w_done;
  assign wb_uop        = w_done ? r_uop : '0;
  assign wb_data       = w_done ? r_data : '0;
  assign wb_misaligned = w_done & r_mis;

endmodule

// File: tb/tb_lsu_mem_pipe.sv
// Directed bench for lsu_mem_pipe: loads, stores, stalls, flushes.
// Expected values are hand-computed from the memory-stage behaviour.
module tb_lsu_mem_pipe;
  import lsu_mem_pipe_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear_en;
  micro_op_t   uop_in;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        ex_busy;
  logic        wb_valid;
  micro_op_t   wb_uop;
  logic [31:0] wb_data;
  logic        wb_misaligned;

  int n_chk = 0;
  int n_err = 0;

  lsu_mem_pipe_if #(.XLEN(32), .STRB_W(4)) mif ();

  lsu_mem_pipe dut (
    .clock         (clock),
    .reset         (reset),
    .clear_en      (clear_en),
    .uop_in        (uop_in),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .ex_busy       (ex_busy),
    .mem           (mif.master),
    .wb_valid      (wb_valid),
    .wb_uop        (wb_uop),
    .wb_data       (wb_data),
    .wb_misaligned (wb_misaligned)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic        st,
                       input logic [1:0]  sz,
                       input logic        uns,
                       input logic [31:0] b,
                       input logic [31:0] imm,
                       input logic [31:0] d);
    uop_in              = '0;
    uop_in.valid        = 1'b1;
    uop_in.is_store     = st;
    uop_in.mem_size     = sz;
    uop_in.mem_unsigned = uns;
    uop_in.rd           = 5'd7;
    uop_in.imm          = imm;
    rs1_data            = b;
    rs2_data            = d;
    step();
    uop_in   = '0;
    rs1_data = '0;
    rs2_data = '0;
  endtask

  task automatic wait_wb(input string tag, output int n);
    n = 0;
    while (!wb_valid && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk({tag, "_timeout"}, 32'(wb_valid), 32'd1);
  endtask

  task automatic do_load(input string tag,
                         input logic [1:0]  sz,
                         input logic        uns,
                         input logic [31:0] b,
                         input logic [31:0] imm,
                         input logic [31:0] rd,
                         input logic [31:0] e_addr,
                         input logic [3:0]  e_strb,
                         input logic [31:0] e_data);
    int n;
    mif.mem_gnt        = 1'b1;
    mif.mem_resp_valid = 1'b1;
    mif.mem_rdata      = rd;
    issue(1'b0, sz, uns, b, imm, 32'h0);
    chk({tag, "_req"}, 32'(mif.mem_req), 32'd1);
    chk({tag, "_addr"}, mif.mem_addr, e_addr);
    chk({tag, "_strb"}, 32'(mif.mem_wstrb), 32'(e_strb));
    wait_wb(tag, n);
    chk({tag, "_lat"}, n, 2);
    chk({tag, "_data"}, wb_data, e_data);
    chk({tag, "_mis"}, 32'(wb_misaligned), 32'd0);
    step();
    chk({tag, "_idle"}, 32'(ex_busy), 32'd0);
    mif.mem_resp_valid = 1'b0;
  endtask

  initial begin
    int n;
    reset              = 1'b1;
    clear_en           = 1'b0;
    uop_in             = '0;
    rs1_data           = '0;
    rs2_data           = '0;
    mif.mem_gnt        = 1'b0;
    mif.mem_resp_valid = 1'b0;
    mif.mem_rdata      = '0;
    step();
    step();
    chk("rst_busy", 32'(ex_busy), 32'd0);
    chk("rst_req", 32'(mif.mem_req), 32'd0);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_wbd", wb_data, 32'd0);
    chk("rst_addr", mif.mem_addr, 32'd0);
    chk("rst_uop", 32'(wb_uop.rd), 32'd0);
    reset = 1'b0;
    step();

    do_load("lw", SZ_W, 1'b0, 32'h1000, 32'd4,
            32'hDEADBEEF, 32'h1004, 4'b1111, 32'hDEADBEEF);
    do_load("lb_s", SZ_B, 1'b0, 32'h1000, 32'd3,
            32'h80FFFFFF, 32'h1003, 4'b1000, 32'hFFFFFF80);
    do_load("lbu", SZ_B, 1'b1, 32'h1000, 32'd3,
            32'h80FFFFFF, 32'h1003, 4'b1000, 32'h00000080);
    do_load("lh_s", SZ_H, 1'b0, 32'h2000, 32'd2,
            32'h80011234, 32'h2002, 4'b1100, 32'hFFFF8001);
    do_load("lhu", SZ_H, 1'b1, 32'h2000, 32'd2,
            32'h80011234, 32'h2002, 4'b1100, 32'h00008001);
    do_load("wrap", SZ_W, 1'b0, 32'hFFFFFFFC, 32'd8,
            32'h01020304, 32'h00000004, 4'b1111, 32'h01020304);

    // store half, zero-wait
    mif.mem_gnt = 1'b1;
    issue(1'b1, SZ_H, 1'b0, 32'h2000, 32'd2, 32'h1234ABCD);
    chk("sh_we", 32'(mif.mem_we), 32'd1);
    chk("sh_strb", 32'(mif.mem_wstrb), 32'hC);
    chk("sh_wdata", mif.mem_wdata, 32'hABCD0000);
    step();
    chk("sh_wbv", 32'(wb_valid), 32'd1);
    chk("sh_wbd", wb_data, 32'd0);
    chk("sh_st", 32'(wb_uop.is_store), 32'd1);
    step();
    chk("sh_done", 32'(wb_valid), 32'd0);

    // grant stall with a dropped uop pulse while busy
    mif.mem_gnt = 1'b0;
    issue(1'b0, SZ_W, 1'b0, 32'h3000, 32'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("gs_req", 32'(mif.mem_req), 32'd1);
      chk("gs_addr", mif.mem_addr, 32'h3000);
      uop_in = '0;
      if (i == 1) begin
        uop_in.valid    = 1'b1;
        uop_in.is_store = 1'b1;
        uop_in.mem_size = SZ_W;
        rs1_data        = 32'h5000;
      end
      if (i == 3) mif.mem_gnt = 1'b1;
      step();
    end
    uop_in             = '0;
    rs1_data           = '0;
    chk("gs_wait", 32'(mif.mem_req), 32'd0);
    mif.mem_resp_valid = 1'b1;
    mif.mem_rdata      = 32'h11223344;
    step();
    chk("gs_wbv", 32'(wb_valid), 32'd1);
    chk("gs_wbd", wb_data, 32'h11223344);
    chk("gs_ld", 32'(wb_uop.is_store), 32'd0);
    mif.mem_resp_valid = 1'b0;
    step();
    chk("gs_drop", 32'(ex_busy), 32'd0);

    // flush while waiting for a load response
    mif.mem_gnt = 1'b1;
    issue(1'b0, SZ_W, 1'b0, 32'h6000, 32'd0, 32'h0);
    step();
    chk("fw_busy0", 32'(ex_busy), 32'd1);
    clear_en = 1'b1;
    step();
    clear_en = 1'b0;
    chk("fw_wbv1", 32'(wb_valid), 32'd0);
    step();
    chk("fw_wbv2", 32'(wb_valid), 32'd0);
    chk("fw_busy2", 32'(ex_busy), 32'd1);
    mif.mem_resp_valid = 1'b1;
    mif.mem_rdata      = 32'hBAD0BAD0;
    step();
    mif.mem_resp_valid = 1'b0;
    chk("fw_busy3", 32'(ex_busy), 32'd0);
    chk("fw_wbv3", 32'(wb_valid), 32'd0);

    // flush in REQ with a same-cycle grant on a store
    issue(1'b1, SZ_W, 1'b0, 32'h4000, 32'd0, 32'h55);
    clear_en = 1'b1;
    step();
    chk("fr_busy", 32'(ex_busy), 32'd0);
    chk("fr_wbv", 32'(wb_valid), 32'd0);

    // clear beats a same-cycle accept in IDLE
    issue(1'b0, SZ_W, 1'b0, 32'h4000, 32'd0, 32'h0);
    clear_en = 1'b0;
    chk("fi_busy", 32'(ex_busy), 32'd0);
    chk("fi_req", 32'(mif.mem_req), 32'd0);

    // reset mid-request
    mif.mem_gnt = 1'b0;
    issue(1'b0, SZ_W, 1'b0, 32'h7000, 32'd0, 32'h0);
    chk("rm_req0", 32'(mif.mem_req), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rm_req", 32'(mif.mem_req), 32'd0);
    chk("rm_busy", 32'(ex_busy), 32'd0);
    step();

`ifdef LSU_MISALIGN_TRAP_EN
    mif.mem_gnt = 1'b1;
    issue(1'b0, SZ_W, 1'b0, 32'h1000, 32'd2, 32'h0);
    chk("mt_req", 32'(mif.mem_req), 32'd0);
    chk("mt_wbv", 32'(wb_valid), 32'd1);
    chk("mt_mis", 32'(wb_misaligned), 32'd1);
    chk("mt_wbd", wb_data, 32'd0);
    step();
    chk("mt_idle", 32'(ex_busy), 32'd0);
`else
    do_load("ma", SZ_W, 1'b0, 32'h1000, 32'd2,
            32'hCAFEF00D, 32'h1000, 4'b1111, 32'hCAFEF00D);
`endif

    n = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
